// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: 5-stage pipeline enables/bubbles for load-use and data-memory wait hazards
// A memory freeze holds the whole front end; load-use only matters when the pipe is moving.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             mem_start,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    state_t      state, state_n;
    logic [15:0] wait_cnt;
    logic        lu, freeze, err, go;
    assign lu = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            state        <= state_n;
            wait_cnt     <= (state == MEM_WAIT && !mem_ready) ? wait_cnt + 16'd1 : '0;
            stall_cycles <= (!pc_en && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
        end
    end
    always_comb begin
        state_n = state;
        if (state == RUN && mem_req && !mem_ready)
            state_n = MEM_WAIT;
        else if (state == MEM_WAIT)
            state_n = mem_ready ? RUN : (wait_cnt == 16'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT;
    end
    // go: pipe may advance (RUN without pending wait, or the completing MEM_WAIT cycle)
    always_comb begin
        freeze       = ((state == RUN && mem_req) || state == MEM_WAIT) && !mem_ready;
        err          = state == ERROR;
        go           = !freeze && !err;
        pc_en        = !rst && go && !lu;
        ifid_en      = !rst && go && !lu;
        idex_flush   = rst || (go && lu);
        exmem_en     = !rst && go;
        memwb_en     = !rst && !err;
        memwb_bubble = rst || freeze || err;
        mem_start    = !rst && state == RUN && mem_req;
        busy         = !rst && state == MEM_WAIT;
        timeout_err  = !rst && err;
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vectors with hand-computed outputs, MEM_TIMEOUT=4, CNT_W=4
module tb_pipe_stall_ctrl;
    logic       clk = 0, rst = 1;
    logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
    logic       ex_mem_read = 0, mem_req = 0, mem_ready = 0;
    logic       pc_en, ifid_en, idex_flush, exmem_en, memwb_en, memwb_bubble, mem_start, busy, timeout_err;
    logic [3:0] stall_cycles;
    int         errors = 0, checks = 0;

    // {pc_en,ifid_en,idex_flush,exmem_en,memwb_en,memwb_bubble,mem_start,busy,timeout_err}
    localparam logic [8:0] O_RST = 9'b001001000, O_RUN = 9'b110110000, O_LU = 9'b001110000,
                           O_ZW = 9'b110110100, O_ST = 9'b000011100, O_WT = 9'b000011010,
                           O_CM = 9'b110110010, O_CL = 9'b001110010, O_ER = 9'b000001001;

    pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en),
        .ifid_en(ifid_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .memwb_bubble(memwb_bubble), .mem_start(mem_start), .busy(busy),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive one cycle, check comb outputs mid-cycle, optionally the counter, then advance
    task automatic vec(input string tag, input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic req, input logic rdy,
                       input logic [8:0] eo, input int es);
        rst = r; ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt; mem_req = req; mem_ready = rdy;
        #2;
        chk(tag, 32'({pc_en, ifid_en, idex_flush, exmem_en, memwb_en, memwb_bubble, mem_start, busy, timeout_err}), 32'(eo));
        if (es >= 0) chk({tag, "_cnt"}, 32'(stall_cycles), 32'(es));
        @(posedge clk); #1;
    endtask

    initial begin
        vec("rst0", 1, 0, 0, 0, 0, 0, 0, O_RST, -1);
        vec("rst1", 1, 0, 0, 0, 0, 0, 0, O_RST, -1);
        vec("post_rst", 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
        vec("lu_rs", 0, 1, 5, 5, 0, 0, 0, O_LU, 0);
        vec("lu_clear", 0, 0, 0, 0, 0, 0, 0, O_RUN, 1);
        vec("lu_r0", 0, 1, 0, 0, 0, 0, 0, O_RUN, 1);
        vec("lu_rt", 0, 1, 7, 3, 7, 0, 0, O_LU, 1);
        vec("lu_nomatch", 0, 1, 7, 3, 4, 0, 0, O_RUN, 2);
        vec("zero_wait", 0, 0, 0, 0, 0, 1, 1, O_ZW, 2);
        vec("zw_after", 0, 0, 0, 0, 0, 0, 0, O_RUN, 2);
        vec("rdy_ignored", 0, 0, 0, 0, 0, 0, 1, O_RUN, 2);
        vec("w3_start", 0, 1, 5, 5, 0, 1, 0, O_ST, 2);
        vec("w3_wait1", 0, 1, 5, 5, 0, 1, 0, O_WT, 3);
        vec("w3_wait2", 0, 1, 5, 5, 0, 1, 0, O_WT, 4);
        vec("w3_done", 0, 0, 0, 0, 0, 0, 1, O_CM, 5);
        vec("w3_after", 0, 0, 0, 0, 0, 0, 0, O_RUN, 5);
        vec("w1_start", 0, 0, 0, 0, 0, 1, 0, O_ST, 5);
        vec("w1_done_lu", 0, 1, 9, 0, 9, 0, 1, O_CL, 6);
        vec("w1_after", 0, 0, 0, 0, 0, 0, 0, O_RUN, 7);
        vec("to_start", 0, 0, 0, 0, 0, 1, 0, O_ST, 7);
        for (int i = 0; i < 4; i++) vec("to_wait", 0, 0, 0, 0, 0, 0, 0, O_WT, 8 + i);
        vec("to_err", 0, 0, 0, 0, 0, 0, 0, O_ER, 12);
        vec("to_err_rdy", 0, 0, 0, 0, 0, 1, 1, O_ER, 13);
        vec("to_rst", 1, 0, 0, 0, 0, 0, 0, O_RST, -1);
        vec("to_recover", 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
        vec("mw_start", 0, 0, 0, 0, 0, 1, 0, O_ST, 0);
        vec("mw_wait", 0, 0, 0, 0, 0, 0, 0, O_WT, 1);
        vec("mw_rst", 1, 0, 0, 0, 0, 0, 0, O_RST, -1);
        vec("mw_recover", 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
        for (int i = 0; i < 20; i++) vec("sat_lu", 0, 1, 5, 5, 0, 0, 0, O_LU, i < 15 ? i : 15);
        vec("sat_end", 0, 0, 0, 0, 0, 0, 0, O_RUN, 15);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
